// File: rtl/innerloop_cmd_dispatch.sv
// innerloop_cmd_dispatch: queues loop commands in a FIFO and issues them one at a time to an innerloop wrapper
// ports: cmd_* command push (valid/ready); loop_ap_* wrapper handshake, loop_init/len/inc FIFO-head operands;
//        rsp_* tagged completion (valid/ready); busy and cmd_count status
module innerloop_cmd_dispatch #(
  parameter int LEN_DWIDTH = 32,
  parameter int INC_DWIDTH = 29,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8
) (
  input  logic                          ap_clk,
  input  logic                          ap_rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [LEN_DWIDTH-1:0]         cmd_init,
  input  logic [LEN_DWIDTH-1:0]         cmd_len,
  input  logic [INC_DWIDTH+2:0]         cmd_inc,
  input  logic [TAG_W-1:0]              cmd_tag,
  output logic                          loop_ap_start,
  input  logic                          loop_ap_ready,
  input  logic                          loop_ap_done,
  input  logic                          loop_ap_idle,
  input  logic [31:0]                   loop_ap_return,
  input  logic [31:0]                   loop_cnt,
  input  logic                          loop_cnt_ap_vld,
  output logic [LEN_DWIDTH-1:0]         loop_init,
  output logic [LEN_DWIDTH-1:0]         loop_len,
  output logic [INC_DWIDTH+2:0]         loop_inc,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [31:0]                   rsp_cnt,
  output logic [31:0]                   rsp_return,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] cmd_count
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [LEN_DWIDTH-1:0] init_m [FIFO_DEPTH];
  logic [LEN_DWIDTH-1:0] len_m  [FIFO_DEPTH];
  logic [INC_DWIDTH+2:0] inc_m  [FIFO_DEPTH];
  logic [TAG_W-1:0]      tag_m  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic up, push, pop, cap, full, empty;
  logic unused_idle;
  assign unused_idle   = loop_ap_idle;
  assign full          = cmd_count == CW'(FIFO_DEPTH);
  assign empty         = cmd_count == '0;
  // up keeps cmd_ready low until the first clock after reset release
  assign cmd_ready     = up && !full;
  assign push          = cmd_valid && cmd_ready;
  assign pop           = state == START && loop_ap_ready;
  assign cap           = (pop && loop_ap_done) || (state == WAIT && loop_ap_done);
  assign loop_ap_start = state == START;
  assign rsp_valid     = state == RESP;
  assign busy          = state != IDLE || !empty;
  assign loop_init     = init_m[rd_ptr];
  assign loop_len      = len_m[rd_ptr];
  assign loop_inc      = inc_m[rd_ptr];
  always_comb begin
    state_nx = state == IDLE  ? (empty ? IDLE : START) :
               state == START ? (!loop_ap_ready ? START : loop_ap_done ? RESP : WAIT) :
               state == WAIT  ? (loop_ap_done ? RESP : WAIT) :
                                (!rsp_ready ? RESP : empty ? IDLE : START);
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      state      <= IDLE;
      up         <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cmd_count  <= '0;
      rsp_tag    <= '0;
      rsp_cnt    <= '0;
      rsp_return <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        init_m[i] <= '0;
        len_m[i]  <= '0;
        inc_m[i]  <= '0;
        tag_m[i]  <= '0;
      end
    end else begin
      state     <= state_nx;
      up        <= 1'b1;
      cmd_count <= cmd_count + CW'(push) - CW'(pop);
      if (push) begin
        init_m[wr_ptr] <= cmd_init;
        len_m[wr_ptr]  <= cmd_len;
        inc_m[wr_ptr]  <= cmd_inc;
        tag_m[wr_ptr]  <= cmd_tag;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rsp_tag <= tag_m[rd_ptr];
      end
      if (cap) begin
        rsp_return <= loop_ap_return;
        rsp_cnt    <= loop_cnt_ap_vld ? loop_cnt : '0;
      end
    end
  end
endmodule

// File: tb/tb_innerloop_cmd_dispatch.sv
// tb_innerloop_cmd_dispatch: scoreboard and vector-table bench for innerloop_cmd_dispatch
module tb_innerloop_cmd_dispatch;
  logic ap_clk = 1'b0, ap_rstn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_init = '0, cmd_len = '0, cmd_inc = '0;
  logic [7:0] cmd_tag = '0;
  logic loop_ap_start, loop_ap_ready = 1'b0, loop_ap_done = 1'b0, loop_ap_idle = 1'b1;
  logic [31:0] loop_ap_return = '0, loop_cnt = '0;
  logic loop_cnt_ap_vld = 1'b0;
  logic [31:0] loop_init, loop_len, loop_inc;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [7:0] rsp_tag;
  logic [31:0] rsp_cnt, rsp_return;
  logic busy;
  logic [2:0] cmd_count;

  innerloop_cmd_dispatch dut (
    .ap_clk(ap_clk), .ap_rstn(ap_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_init(cmd_init), .cmd_len(cmd_len),
    .cmd_inc(cmd_inc), .cmd_tag(cmd_tag),
    .loop_ap_start(loop_ap_start), .loop_ap_ready(loop_ap_ready), .loop_ap_done(loop_ap_done),
    .loop_ap_idle(loop_ap_idle), .loop_ap_return(loop_ap_return), .loop_cnt(loop_cnt),
    .loop_cnt_ap_vld(loop_cnt_ap_vld),
    .loop_init(loop_init), .loop_len(loop_len), .loop_inc(loop_inc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_cnt(rsp_cnt),
    .rsp_return(rsp_return), .busy(busy), .cmd_count(cmd_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] init, len, inc, cnt, ret;
    logic [7:0]  tag;
  } exp_t;
  typedef struct {
    logic [31:0] init, len, inc;
    logic [7:0]  tag;
    bit          same, novld;
    int          dly;
    logic [31:0] ecnt, eret;
  } vec_t;

  exp_t iss_q[$], rsp_q[$];
  int checks = 0, errors = 0;
  bit stall = 1'b0, same = 1'b0, novld = 1'b0, spur = 1'b0;
  int dly = 2, dcnt = 0;
  logic [31:0] cur_init, cur_len;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #2;
  endtask

  // Wrapper model: accepts a start in the cycle it sees it, finishes dly cycles later
  // (or in the same cycle when same=1), reporting cnt=len and return=init.
  task automatic finish_cmd();
    loop_ap_done    = 1'b1;
    loop_cnt_ap_vld = !novld;
    loop_cnt        = cur_len;
    loop_ap_return  = cur_init;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge ap_clk);
      #1;
      loop_ap_ready   = 1'b0;
      loop_ap_done    = 1'b0;
      loop_cnt_ap_vld = 1'b0;
      loop_cnt        = 32'hBAD0_0000;
      loop_ap_return  = 32'hBAD0_0001;
      if (!ap_rstn) dcnt = 0;
      else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) finish_cmd();
      end else if (loop_ap_start && !stall) begin
        loop_ap_ready = 1'b1;
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: got start with no queued command, required none");
        end else begin
          e = iss_q.pop_front();
          chk("loop_init", loop_init, e.init);
          chk("loop_len", loop_len, e.len);
          chk("loop_inc", loop_inc, e.inc);
        end
        cur_init = loop_init;
        cur_len  = loop_len;
        if (same) finish_cmd();
        else dcnt = dly;
      end else if (spur) begin
        spur            = 1'b0;
        loop_ap_done    = 1'b1;
        loop_cnt_ap_vld = 1'b1;
        loop_cnt        = 32'd99;
        loop_ap_return  = 32'hDEAD;
      end
      loop_ap_idle = dcnt == 0;
    end
  end

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rstn && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got tag %0h, required no response", rsp_tag);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_cnt", rsp_cnt, e.cnt);
        chk("rsp_return", rsp_return, e.ret);
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] l, input logic [31:0] n,
                      input logic [7:0] t, input logic [31:0] ec, input logic [31:0] er);
    int w = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_init  = i;
    cmd_len   = l;
    cmd_inc   = n;
    cmd_tag   = t;
    while (!cmd_ready && w < 300) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got cmd_ready 0, required 1 within 300 cycles");
    end else begin
      e = '{init: i, len: l, inc: n, cnt: ec, ret: er, tag: t};
      iss_q.push_back(e);
      rsp_q.push_back(e);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((rsp_q.size() != 0 || busy) && w < 500) begin
      step();
      w++;
    end
    chk("drain_done", w < 500, 1);
  endtask

  vec_t vt[5];

  initial begin
    int w;
    vt[0] = '{32'h2A, 32'd7, 32'd3, 8'h21, 1'b1, 1'b0, 0, 32'd7, 32'h2A};
    vt[1] = '{32'h1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h22, 1'b0, 1'b1, 2, 32'd0, 32'h1000};
    vt[2] = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 8'h23, 1'b0, 1'b0, 1, 32'd0, 32'hFFFF_FFFF};
    vt[3] = '{32'h5555_AAAA, 32'd3, 32'd2, 8'hFF, 1'b0, 1'b0, 4, 32'd3, 32'h5555_AAAA};
    vt[4] = '{32'd0, 32'd1, 32'd1, 8'h00, 1'b1, 1'b1, 0, 32'd0, 32'd0};
    // reset state
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", loop_ap_start, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_loop_init", loop_init, 0);
    ap_rstn = 1'b1;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    // single command latency: accept T, start T+2 only, done T+8, rsp T+9, idle T+10
    dly = 6;
    send(32'd0, 32'd5, 32'd1, 8'h11, 32'd5, 32'd0);
    chk("t1_start_T1", loop_ap_start, 0);
    chk("t1_count_T1", cmd_count, 1);
    chk("t1_busy_T1", busy, 1);
    step();
    chk("t1_start_T2", loop_ap_start, 1);
    step();
    chk("t1_start_T3", loop_ap_start, 0);
    repeat (5) step();
    chk("t1_rsp_valid_T8", rsp_valid, 0);
    step();
    chk("t1_rsp_valid_T9", rsp_valid, 1);
    chk("t1_rsp_tag_T9", rsp_tag, 8'h11);
    chk("t1_busy_T9", busy, 1);
    step();
    chk("t1_busy_T10", busy, 0);
    chk("t1_rsp_valid_T10", rsp_valid, 0);
    // vector table: one command per record, drained before the next
    for (int k = 0; k < 5; k++) begin
      same  = vt[k].same;
      novld = vt[k].novld;
      dly   = vt[k].dly;
      send(vt[k].init, vt[k].len, vt[k].inc, vt[k].tag, vt[k].ecnt, vt[k].eret);
      drain();
    end
    same  = 1'b0;
    novld = 1'b0;
    // same-cycle ready and done: START->RESP directly, rsp_valid at T+3
    same = 1'b1;
    send(32'h2A, 32'd9, 32'd1, 8'h2A, 32'd9, 32'h2A);
    step();
    chk("t4_start_T2", loop_ap_start, 1);
    step();
    chk("t4_rsp_valid_T3", rsp_valid, 1);
    chk("t4_rsp_return", rsp_return, 32'h2A);
    drain();
    same = 1'b0;
    // FIFO full with the wrapper stalled: 5th command blocked until the first pop
    stall = 1'b1;
    dly   = 2;
    for (int k = 1; k <= 4; k++) send(32'(k * 16), 32'(k), 32'd1, 8'(k), 32'(k), 32'(k * 16));
    cmd_valid = 1'b1;
    cmd_tag   = 8'd5;
    for (int k = 0; k < 3; k++) begin
      chk("t2_full_ready", cmd_ready, 0);
      chk("t2_full_count", cmd_count, 4);
      chk("t2_stalled_start", loop_ap_start, 1);
      step();
    end
    stall = 1'b0;
    send(32'd80, 32'd5, 32'd1, 8'd5, 32'd5, 32'd80);
    drain();
    // response stall with two entries queued
    rsp_ready = 1'b0;
    dly = 3;
    send(32'h100, 32'd2, 32'd1, 8'h31, 32'd2, 32'h100);
    send(32'h200, 32'd4, 32'd1, 8'h32, 32'd4, 32'h200);
    send(32'h300, 32'd6, 32'd1, 8'h33, 32'd6, 32'h300);
    w = 0;
    while (!rsp_valid && w < 50) begin
      step();
      w++;
    end
    chk("t3_rsp_arrives", rsp_valid, 1);
    chk("t3_count", cmd_count, 2);
    for (int k = 0; k < 10; k++) begin
      chk("t3_no_start", loop_ap_start, 0);
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_tag", rsp_tag, 8'h31);
      chk("t3_rsp_cnt", rsp_cnt, 2);
      chk("t3_rsp_return", rsp_return, 32'h100);
      step();
    end
    rsp_ready = 1'b1;
    chk("t3_start_R", loop_ap_start, 0);
    step();
    chk("t3_start_R1", loop_ap_start, 1);
    drain();
    // spurious done while idle
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_busy", busy, 0);
    end
    // reset during WAIT with three queued
    dly = 20;
    for (int k = 1; k <= 4; k++) send(32'(k), 32'(k), 32'd1, 8'(8'h40 + k), 32'(k), 32'(k));
    chk("t6_count_before", cmd_count, 3);
    chk("t6_start_before", loop_ap_start, 0);
    ap_rstn = 1'b0;
    step();
    chk("t6_count", cmd_count, 0);
    chk("t6_start", loop_ap_start, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_busy", busy, 0);
    iss_q.delete();
    rsp_q.delete();
    ap_rstn = 1'b1;
    step();
    chk("t6_cmd_ready_after", cmd_ready, 1);
    dly = 2;
    send(32'h77, 32'd3, 32'd2, 8'h51, 32'd3, 32'h77);
    drain();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/innerloop_cmd_dispatch.md
Name: innerloop_cmd_dispatch

Overview:
- Upstream command stage for an innerloop_<submodule> wrapper.
- Buffers loop commands (init/len/inc plus a tag) in a small FIFO and issues them one at a time over the wrapper's ap_start/ap_ready/ap_done handshake.
- Captures the completion count and return value per command and presents them as a tagged response on a valid/ready port.
- Allows a control processor to queue several loop invocations without polling ap_idle.

Parameters:
- LEN_DWIDTH, 32, width of loop_init / loop_len.
- INC_DWIDTH, 29, loop_inc width is INC_DWIDTH+3.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2.
- TAG_W, 8, command tag width.

Ports:
- ap_clk  in  1  clock.
- ap_rstn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_init  in  LEN_DWIDTH  loop start value.
- cmd_len  in  LEN_DWIDTH  loop length.
- cmd_inc  in  INC_DWIDTH+3  loop increment.
- cmd_tag  in  TAG_W  opaque tag, echoed in the response.
- loop_ap_start  out  1  start to the innerloop wrapper.
- loop_ap_ready  in  1  wrapper accepted start.
- loop_ap_done  in  1  wrapper finished (single-cycle pulse).
- loop_ap_idle  in  1  wrapper idle (status only).
- loop_ap_return  in  32  wrapper return value.
- loop_cnt  in  32  wrapper done count.
- loop_cnt_ap_vld  in  1  loop_cnt valid.
- loop_init  out  LEN_DWIDTH  FIFO head init.
- loop_len  out  LEN_DWIDTH  FIFO head len.
- loop_inc  out  INC_DWIDTH+3  FIFO head inc.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_cnt  out  32  captured loop_cnt.
- rsp_return  out  32  captured loop_ap_return.
- busy  out  1  state != IDLE or FIFO not empty.
- cmd_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset: the clock and reset are the single clock ap_clk and synchronous active-low reset ap_rstn. While ap_rstn=0 at a clock edge:
  - FIFO is flushed and pointers/occupancy are zeroed.
  - State returns to IDLE.
  - All outputs are 0: cmd_ready becomes 1 in the first cycle after reset release.
  - Reset mid-operation abandons the in-flight command with no response; loop_ap_start drops immediately.
- FIFO push/pop:
  - Push when cmd_valid && cmd_ready.
  - No bypass: a pushed entry becomes visible to the FSM the next cycle.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: occupancy unchanged.
- loop_init/len/inc always reflect the FIFO head. They are stable throughout START and WAIT because pop happens only at the START exit.
- FSM states: IDLE, START, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, go to START next cycle.
  - START:
    - loop_ap_start=1, combinational from state.
    - On loop_ap_ready: pop the FIFO and latch the head tag into tag_r.
    - If loop_ap_done is also high in the same cycle, capture and go to RESP. Otherwise go to WAIT.
    - Hold in START until ready.
  - WAIT:
    - loop_ap_start=0.
    - On loop_ap_done: capture rsp_return<=loop_ap_return.
    - rsp_cnt<=loop_cnt if loop_cnt_ap_vld, else 0.
    - Go to RESP.
  - RESP:
    - rsp_valid=1; rsp_* held stable until rsp_ready.
    - On rsp_ready: go to START if the FIFO is non-empty (count evaluated post-pop), else IDLE.
- loop_ap_done outside START/WAIT is ignored (no capture, no state change).
- Only one command is outstanding at the innerloop. A new start never issues before the previous response is accepted.
- Latency with an empty FIFO in IDLE: accept at cycle T, loop_ap_start high at T+2. Done at cycle D gives rsp_valid high at D+1.
- busy=1 whenever state != IDLE or cmd_count != 0.

Test Plan:
- Single command init=0, len=5, inc=1, tag=0x11; wrapper model does ready same cycle, done 6 cycles later with loop_cnt=5, return=0 -> loop_ap_start high exactly 1 cycle at T+2; rsp_valid with tag=0x11, cnt=5, return=0; busy drops the cycle after rsp handshake.
- Queue 5 commands back-to-back with FIFO_DEPTH=4 and the wrapper stalled (ap_ready=0) -> 5th command blocked with cmd_ready=0 until the first pop; responses arrive in order with tags 1..5.
- rsp_ready held low 10 cycles in RESP, FIFO holding 2 entries -> no loop_ap_start during the stall; rsp_* stable; next start issues the cycle after rsp_ready.
- loop_ap_ready and loop_ap_done in the same cycle, return=0x2A -> direct START->RESP, rsp_return=0x2A, rsp_cnt=loop_cnt.
- Spurious loop_ap_done pulse in IDLE -> no rsp_valid, no state change.
- ap_rstn=0 for 1 cycle during WAIT with 3 queued -> cmd_count=0, loop_ap_start=0, rsp_valid=0, no response for the aborted command; new command after reset completes normally.
